// File: rtl/solver_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : solver_job_dispatcher
// Brief    : Queues operand jobs, runs them one at a time on expression_solver,
//            and returns tagged results with a watchdog abort path.
// Revision : 1.0  initial release
// ============================================================================
module solver_job_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [7:0]  job_x,
    input  logic [15:0] job_a,
    input  logic [15:0] job_b,
    input  logic [15:0] job_c,
    output logic        sol_rst,
    output logic        sol_start,
    output logic [7:0]  sol_x,
    output logic [15:0] sol_a,
    output logic [15:0] sol_b,
    output logic [15:0] sol_c,
    input  logic [15:0] sol_result,
    input  logic        sol_zero,
    input  logic        sol_overflow,
    input  logic        sol_completed,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_zero,
    output logic        res_overflow,
    output logic        res_timeout,
    output logic [7:0]  res_tag
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw = c_aw + 1;
    localparam int c_tw = $clog2(TIMEOUT + 1);
    localparam int c_jw = 8 + 3 * 16;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_run   = 2'd1;
    localparam logic [1:0] c_flush = 2'd2;
    localparam logic [1:0] c_hold  = 2'd3;

    // The timer is cleared on the pop edge, so the (TIMEOUT-1)th RUN edge sees TIMEOUT-2.
    localparam logic [c_tw-1:0] c_abort_at = c_tw'(TIMEOUT - 2);
    localparam logic [c_cw-1:0] c_full     = c_cw'(DEPTH);

    logic [c_jw-1:0] r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;

    logic [1:0]      r_state;
    logic [c_tw-1:0] r_timer;
    logic            r_flush_cnt;
    logic [7:0]      r_tag_cnt;

    logic            r_sol_start;
    logic [7:0]      r_sol_x;
    logic [15:0]     r_sol_a;
    logic [15:0]     r_sol_b;
    logic [15:0]     r_sol_c;
    logic            r_res_valid;
    logic [15:0]     r_res_data;
    logic            r_res_zero;
    logic            r_res_overflow;
    logic            r_res_timeout;
    logic [7:0]      r_res_tag;

    logic            w_push;
    logic            w_pop;
    logic [c_jw-1:0] w_head;
    logic            w_flush_active;

    assign job_ready      = (r_count != c_full);
    assign w_push         = job_valid & job_ready;
    assign w_pop          = (r_state == c_idle) && (r_count != '0);
    assign w_head         = r_mem[r_rd_ptr];
    assign w_flush_active = (r_state == c_flush);
    assign sol_rst        = ~rst | w_flush_active;

    assign sol_start    = r_sol_start;
    assign sol_x        = r_sol_x;
    assign sol_a        = r_sol_a;
    assign sol_b        = r_sol_b;
    assign sol_c        = r_sol_c;
    assign res_valid    = r_res_valid;
    assign res_data     = r_res_data;
    assign res_zero     = r_res_zero;
    assign res_overflow = r_res_overflow;
    assign res_timeout  = r_res_timeout;
    assign res_tag      = r_res_tag;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {job_x, job_a, job_b, job_c};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= c_idle;
            r_timer        <= '0;
            r_flush_cnt    <= 1'b0;
            r_tag_cnt      <= '0;
            r_sol_start    <= 1'b0;
            r_sol_x        <= '0;
            r_sol_a        <= '0;
            r_sol_b        <= '0;
            r_sol_c        <= '0;
            r_res_valid    <= 1'b0;
            r_res_data     <= '0;
            r_res_zero     <= 1'b0;
            r_res_overflow <= 1'b0;
            r_res_timeout  <= 1'b0;
            r_res_tag      <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_sol_start <= 1'b0;
                    if (w_pop) begin
                        {r_sol_x, r_sol_a, r_sol_b, r_sol_c} <= w_head;
                        r_res_tag   <= r_tag_cnt;
                        r_tag_cnt   <= r_tag_cnt + 1'b1;
                        r_timer     <= '0;
                        r_sol_start <= 1'b1;
                        r_state     <= c_run;
                    end
                end
                c_run: begin
                    r_timer <= r_timer + 1'b1;
                    if (sol_completed) begin
                        r_res_data     <= sol_result;
                        r_res_zero     <= sol_zero;
                        r_res_overflow <= sol_overflow;
                        r_res_timeout  <= 1'b0;
                        r_res_valid    <= 1'b1;
                        r_sol_start    <= 1'b0;
                        r_state        <= c_hold;
                    end else if (r_timer == c_abort_at) begin
                        r_res_data     <= '0;
                        r_res_zero     <= 1'b0;
                        r_res_overflow <= 1'b0;
                        r_res_timeout  <= 1'b1;
                        r_sol_start    <= 1'b0;
                        r_flush_cnt    <= 1'b0;
                        r_state        <= c_flush;
                    end
                end
                c_flush: begin
                    // Two cycles of solver reset, then report the aborted job.
                    if (r_flush_cnt) begin
                        r_res_valid <= 1'b1;
                        r_state     <= c_hold;
                    end else begin
                        r_flush_cnt <= 1'b1;
                    end
                end
                c_hold: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_solver_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_solver_job_dispatcher
// Brief    : Directed bench for solver_job_dispatcher with a 5-cycle stub solver.
// Revision : 1.0  initial release
// ============================================================================
module tb_solver_job_dispatcher;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [7:0]  job_x;
    logic [15:0] job_a, job_b, job_c;
    logic        sol_rst, sol_start;
    logic [7:0]  sol_x;
    logic [15:0] sol_a, sol_b, sol_c;
    logic [15:0] sol_result;
    logic        sol_zero, sol_overflow, sol_completed;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic        res_zero, res_overflow, res_timeout;
    logic [7:0]  res_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    solver_job_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_x(job_x), .job_a(job_a), .job_b(job_b), .job_c(job_c),
        .sol_rst(sol_rst), .sol_start(sol_start),
        .sol_x(sol_x), .sol_a(sol_a), .sol_b(sol_b), .sol_c(sol_c),
        .sol_result(sol_result), .sol_zero(sol_zero), .sol_overflow(sol_overflow),
        .sol_completed(sol_completed),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_zero(res_zero), .res_overflow(res_overflow), .res_timeout(res_timeout),
        .res_tag(res_tag)
    );

    // Stub solver: one-cycle completed pulse 5 cycles after start rises.
    logic        stub_mute;
    logic        r_prev;
    logic [2:0]  r_cnt;
    logic [17:0] w_sum;

    assign w_sum         = {2'b00, sol_a} + {2'b00, sol_b} + {2'b00, sol_c};
    assign sol_result    = w_sum[15:0];
    assign sol_zero      = (w_sum[15:0] == 16'h0000);
    assign sol_overflow  = |w_sum[17:16];

    always_ff @(posedge clk) begin
        if (sol_rst) begin
            r_prev        <= 1'b0;
            r_cnt         <= '0;
            sol_completed <= 1'b0;
        end else begin
            r_prev        <= sol_start;
            sol_completed <= 1'b0;
            if (sol_start && !r_prev) begin
                r_cnt <= 3'd1;
            end else if (r_cnt != 3'd0) begin
                if (r_cnt == 3'd4) begin
                    sol_completed <= ~stub_mute;
                    r_cnt         <= 3'd0;
                end else begin
                    r_cnt <= r_cnt + 3'd1;
                end
            end
        end
    end

    typedef struct {
        logic [7:0]  x;
        logic [15:0] a, b, c;
        logic [15:0] data;
        logic        zero, ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [7:0] x, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, output logic [15:0] d, output logic z,
                           output logic o, output logic t, output logic [7:0] tag,
                           output int starts, output int cycles, output int rsts,
                           output logic v_after);
        chk("push_ready", 32'(job_ready), 1);
        job_valid = 1'b1; job_x = x; job_a = a; job_b = b; job_c = c;
        step();
        job_valid = 1'b0;
        starts = 0; cycles = 0; rsts = 0;
        while (cycles < 200) begin
            step();
            cycles++;
            if (res_valid) break;
            if (sol_start) starts++;
            if (sol_rst) rsts++;
        end
        chk("res_wait", 32'(res_valid), 1);
        d = res_data; z = res_zero; o = res_overflow; t = res_timeout; tag = res_tag;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        v_after = res_valid;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [15:0] d;
        logic        z, o, t, va;
        logic [7:0]  tg;
        int          st, cy, rs, got, exp_tag;
        logic        pend, saw;

        vecs[0] = '{x: 8'd15,  a: 16'd96,   b: 16'd3,    c: 16'd1,    data: 16'd100,  zero: 1'b0, ovf: 1'b0};
        vecs[1] = '{x: 8'h00,  a: 16'hFFFF, b: 16'h0001, c: 16'h0000, data: 16'h0000, zero: 1'b1, ovf: 1'b1};
        vecs[2] = '{x: 8'hAA,  a: 16'h0000, b: 16'h0000, c: 16'h0000, data: 16'h0000, zero: 1'b1, ovf: 1'b0};
        vecs[3] = '{x: 8'h07,  a: 16'h8000, b: 16'h8000, c: 16'h0001, data: 16'h0001, zero: 1'b0, ovf: 1'b1};
        vecs[4] = '{x: 8'hFF,  a: 16'h1234, b: 16'h1111, c: 16'h0101, data: 16'h2446, zero: 1'b0, ovf: 1'b0};
        vecs[5] = '{x: 8'h3C,  a: 16'hFFFE, b: 16'h0001, c: 16'h0001, data: 16'h0000, zero: 1'b1, ovf: 1'b1};

        rst = 1'b0; job_valid = 1'b0; res_ready = 1'b0; stub_mute = 1'b0;
        job_x = '0; job_a = '0; job_b = '0; job_c = '0;
        step(); step();
        chk("rst_sol_rst", 32'(sol_rst), 1);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_sol_start", 32'(sol_start), 0);
        chk("rst_job_ready", 32'(job_ready), 1);
        chk("rst_res_tag", 32'(res_tag), 0);
        chk("rst_sol_x", 32'(sol_x), 0);
        chk("rst_res_data", 32'(res_data), 0);
        rst = 1'b1;
        #1;
        chk("run_sol_rst", 32'(sol_rst), 0);

        // Table of single jobs, each run to completion and acknowledged.
        exp_tag = 0;
        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].x, vecs[i].a, vecs[i].b, vecs[i].c, d, z, o, t, tg, st, cy, rs, va);
            chk($sformatf("v%0d_data", i), 32'(d), 32'(vecs[i].data));
            chk($sformatf("v%0d_zero", i), 32'(z), 32'(vecs[i].zero));
            chk($sformatf("v%0d_ovf", i), 32'(o), 32'(vecs[i].ovf));
            chk($sformatf("v%0d_timeout", i), 32'(t), 0);
            chk($sformatf("v%0d_tag", i), 32'(tg), 32'(exp_tag));
            chk($sformatf("v%0d_start_cycles", i), 32'(st), 6);
            chk($sformatf("v%0d_latency", i), 32'(cy), 7);
            chk($sformatf("v%0d_sol_x", i), 32'(sol_x), 32'(vecs[i].x));
            chk($sformatf("v%0d_valid_after_ack", i), 32'(va), 0);
            exp_tag++;
        end

        // Fill the FIFO behind a stalled result port.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill%0d_ready", i), 32'(job_ready), 1);
            job_valid = 1'b1; job_x = 8'(i); job_a = 16'(i * 10); job_b = 16'd1; job_c = 16'd0;
            step();
        end
        chk("fifo_full_ready", 32'(job_ready), 0);
        job_x = 8'd5; job_a = 16'd50; job_b = 16'd1; job_c = 16'd0;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (job_ready) saw = 1'b1;
        end
        chk("sixth_offer_held", 32'(saw), 0);
        res_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 400 && got < 6; cyc++) begin
            if (res_valid) begin
                chk($sformatf("burst%0d_tag", got), 32'(res_tag), 32'(exp_tag));
                chk($sformatf("burst%0d_data", got), 32'(res_data), 32'(got * 10 + 1));
                got++;
                exp_tag++;
            end
            pend = job_valid & job_ready;
            step();
            if (pend) job_valid = 1'b0;
        end
        chk("burst_count", 32'(got), 6);
        res_ready = 1'b0;
        step();

        // Watchdog abort, then a normal job.
        stub_mute = 1'b1;
        run_job(8'h11, 16'h0010, 16'h0020, 16'h0030, d, z, o, t, tg, st, cy, rs, va);
        chk("to_timeout", 32'(t), 1);
        chk("to_data", 32'(d), 0);
        chk("to_zero", 32'(z), 0);
        chk("to_ovf", 32'(o), 0);
        chk("to_tag", 32'(tg), 32'(exp_tag));
        chk("to_sol_rst_cycles", 32'(rs), 2);
        chk("to_start_cycles", 32'(st), TIMEOUT - 1);
        chk("to_latency", 32'(cy), TIMEOUT + 2);
        exp_tag++;
        stub_mute = 1'b0;
        run_job(8'h12, 16'h0010, 16'h0020, 16'h0030, d, z, o, t, tg, st, cy, rs, va);
        chk("after_to_timeout", 32'(t), 0);
        chk("after_to_data", 32'(d), 32'h0060);
        chk("after_to_tag", 32'(tg), 32'(exp_tag));
        exp_tag++;

        // Reset in the middle of a job with two more queued.
        for (int i = 0; i < 3; i++) begin
            job_valid = 1'b1; job_x = 8'(i); job_a = 16'(i + 1); job_b = 16'd0; job_c = 16'd0;
            step();
        end
        job_valid = 1'b0;
        step();
        chk("mid_in_run", 32'(sol_start), 1);
        rst = 1'b0;
        #1;
        chk("mid_sol_rst", 32'(sol_rst), 1);
        step();
        rst = 1'b1;
        chk("mid_sol_start", 32'(sol_start), 0);
        chk("mid_res_valid", 32'(res_valid), 0);
        chk("mid_job_ready", 32'(job_ready), 1);
        chk("mid_sol_x", 32'(sol_x), 0);
        saw = 1'b0; st = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (res_valid) saw = 1'b1;
            if (sol_start) st++;
        end
        chk("mid_no_stale_result", 32'(saw), 0);
        chk("mid_no_stale_start", 32'(st), 0);
        exp_tag = 0;
        run_job(8'h21, 16'h0001, 16'h0002, 16'h0003, d, z, o, t, tg, st, cy, rs, va);
        chk("mid_next_tag", 32'(tg), 0);
        chk("mid_next_data", 32'(d), 6);
        exp_tag++;

        // Tag wrap: 257 jobs after a fresh reset.
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_tag = 0;
        for (int j = 0; j < 257; j++) begin
            run_job(8'(j), 16'(j), 16'd0, 16'd0, d, z, o, t, tg, st, cy, rs, va);
            chk($sformatf("wrap%0d_tag", j), 32'(tg), 32'(exp_tag));
            exp_tag = (exp_tag + 1) % 256;
        end
        chk("wrap_last_tag", 32'(tg), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
